wta_selector: RTL and testbench
===============================

WTA_SELECTOR -- requirements
Module: wta_selector

Interface
REQ-001 Parameter NG, default 8, number of neuron groups.
REQ-002 Parameter NPG, default 18, neurons per group.
REQ-003 Parameter CW, default 7, spike-count width, unsigned.
REQ-004 Parameter IW, default 25, inhibition width, two's complement.
REQ-005 Parameter INH_MAX, default 655360, upper inhibition clamp; INH_MIN, default -655360, lower clamp.
REQ-006 Derived WW = clog2(NG*NPG), winner index width (8 at defaults).
REQ-007 clk  in  1  clock, rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 i_start  in  1  request a winner search; sampled only in IDLE.
REQ-010 i_clr  in  1  synchronous abort/clear.
REQ-011 i_cnt  in  NG*NPG*CW  packed counts; neuron n of group g at bits [(g*NPG+n)*CW +: CW].
REQ-012 i_min_cnt  in  CW  minimum count for a valid winner.
REQ-013 i_inhbt  in  NG*IW  packed signed per-group inhibition; group g at [g*IW +: IW].
REQ-014 i_inh_valid  in  NG  per-group inhibition valid.
REQ-015 o_busy  out  1  search in progress.
REQ-016 o_valid  out  1  one-cycle result strobe.
REQ-017 o_winner  out  WW  global winner index g*NPG+n.
REQ-018 o_max  out  CW  winner count.
REQ-019 o_none  out  1  max below i_min_cnt.
REQ-020 o_inh  out  IW  clamped inhibition sum, signed.
REQ-021 o_inh_upd  out  1  one-cycle strobe when o_inh is updated.

Function
REQ-022 FSM states IDLE, SCAN, DONE; IDLE->SCAN on i_start; SCAN->DONE after NG cycles; DONE->IDLE unconditionally.
REQ-023 On the i_start edge in IDLE, i_cnt and i_min_cnt are captured into internal registers; later input changes do not affect that search.
REQ-024 SCAN processes group g = 0..NG-1, one per cycle: combinational max over NPG entries, lowest neuron index wins ties.
REQ-025 The running max updates only on strictly greater group max, so the lowest global index wins ties across groups.
REQ-026 Running max/index initialise to 0/0 on entry to SCAN.
REQ-027 Latency: i_start sampled at edge T -> o_valid high for exactly the cycle after edge T+NG+1 (DONE state).
REQ-028 o_winner, o_max and o_none update only at DONE entry and hold until the next DONE.
REQ-029 If final max < captured i_min_cnt: o_none=1, o_winner=0, o_max=true max; otherwise o_none=0.
REQ-030 o_busy = 1 in SCAN and DONE; i_start is ignored while o_busy=1.
REQ-031 Winner index arithmetic g*NPG+n is performed at width WW with no truncation.
REQ-032 Inhibition: in a cycle with i_inh_valid == all ones, the NG inputs are summed at IW+clog2(NG) bits, clamped to [INH_MIN, INH_MAX], and registered into o_inh; o_inh_upd is high the following cycle.
REQ-033 If i_inh_valid is not all ones, o_inh holds and o_inh_upd=0.
REQ-034 i_clr=1: FSM->IDLE, no o_valid for the aborted search, o_inh<=0, o_inh_upd=0; i_clr takes priority over i_start and inhibition update in the same cycle.
REQ-035 Result registers are not cleared by i_clr.

Reset
REQ-036 reset_n low: FSM=IDLE, o_busy=0, o_valid=0, o_winner=0, o_max=0, o_none=0, o_inh=0, o_inh_upd=0, captured registers 0; applies immediately, including mid-SCAN.
REQ-037 First i_start is accepted at the first rising edge after reset_n deasserts.

Verification (defaults NG=8, NPG=18, CW=7)
REQ-038 Count 40 at g3 n5, all others 10, i_min_cnt=1 -> o_valid at edge T+9: o_winner=59, o_max=40, o_none=0.
REQ-039 Count 50 at g1 n2 and g6 n0, all others 0 -> o_winner=20, o_max=50; all counts 0 with i_min_cnt=0 -> o_winner=0, o_none=0.
REQ-040 All counts <=4, one count 4 at index 100, i_min_cnt=5 -> o_none=1, o_winner=0, o_max=4.
REQ-041 All 8 inhibition inputs = 100000, valid=0xFF -> o_inh=655360; all = -100000 -> o_inh=-655360; sum 1234 -> o_inh=1234; valid=0x7F -> o_inh holds, o_inh_upd=0.
REQ-042 i_cnt changed after the start edge, plus a second i_start while busy -> single o_valid carrying the captured-data result; reset_n pulsed at SCAN cycle 4 -> all outputs 0, no o_valid.
REQ-043 i_clr together with i_start and valid=0xFF -> stays IDLE, o_inh=0, no strobes.

Source files
------------

// File: rtl/wta_selector_if.sv
// wta_selector_if: search request/result and inhibition bundle
// for the winner-take-all selector.
interface wta_selector_if #(
  parameter int NG  = 8,
  parameter int NPG = 18,
  parameter int CW  = 7,
  parameter int IW  = 25,
  parameter int WW  = $clog2(NG*NPG)
);
  logic                  i_start;
  logic                  i_clr;
  logic [NG*NPG*CW-1:0]  i_cnt;
  logic [CW-1:0]         i_min_cnt;
  logic [NG*IW-1:0]      i_inhbt;
  logic [NG-1:0]         i_inh_valid;
  logic                  o_busy;
  logic                  o_valid;
  logic [WW-1:0]         o_winner;
  logic [CW-1:0]         o_max;
  logic                  o_none;
  logic [IW-1:0]         o_inh;
  logic                  o_inh_upd;

  modport master (
    output i_start, i_clr, i_cnt, i_min_cnt,
    output i_inhbt, i_inh_valid,
    input  o_busy, o_valid, o_winner, o_max,
    input  o_none, o_inh, o_inh_upd
  );

  modport slave (
    input  i_start, i_clr, i_cnt, i_min_cnt,
    input  i_inhbt, i_inh_valid,
    output o_busy, o_valid, o_winner, o_max,
    output o_none, o_inh, o_inh_upd
  );
endinterface

// File: rtl/wta_selector.sv
// wta_selector: group-serial winner-take-all search over
// captured spike counts, plus clamped inhibition summation.
module wta_selector #(
  parameter int NG      = 8,
  parameter int NPG     = 18,
  parameter int CW      = 7,
  parameter int IW      = 25,
  parameter int INH_MAX = 655360,
  parameter int INH_MIN = -655360
) (
  input logic           clk,
  input logic           reset_n,
  wta_selector_if.slave bus
);
  localparam int WW = $clog2(NG*NPG);
  localparam int NW = (NPG > 1) ? $clog2(NPG) : 1;
  localparam int GW = $clog2(NG+1);
  localparam int SW = IW + $clog2(NG);
  localparam logic signed [SW-1:0] L_MAX = SW'(INH_MAX);
  localparam logic signed [SW-1:0] L_MIN = SW'(INH_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NG*NPG*CW-1:0] r_cnt;
  logic [CW-1:0]        r_min;
  logic [GW-1:0]        r_g;
  logic [CW-1:0]        r_max;
  logic [WW-1:0]        r_idx;
  logic [WW-1:0]        r_win;
  logic [CW-1:0]        r_max_o;
  logic                 r_none;
  logic [IW-1:0]        r_inh;
  logic                 r_inh_upd;

  logic                 w_last;
  logic [GW-1:0]        w_gsel;
  logic [CW-1:0]        w_gmax;
  logic [NW-1:0]        w_nidx;
  logic [WW-1:0]        w_gidx;
  logic signed [SW-1:0] w_sum;
  logic [IW-1:0]        w_inh;
  logic                 w_inh_all;

  assign w_last    = (r_g == GW'(NG));
  // r_g reaches NG on the flush cycle; keep the select in range
  assign w_gsel    = w_last ? '0 : r_g;
  assign w_inh_all = &bus.i_inh_valid;

  always_comb begin
    int base;
    base   = int'(w_gsel) * NPG;
    w_gmax = r_cnt[base*CW +: CW];
    w_nidx = '0;
    for (int n = 1; n < NPG; n++) begin
      if (r_cnt[(base+n)*CW +: CW] > w_gmax) begin
        w_gmax = r_cnt[(base+n)*CW +: CW];
        w_nidx = NW'(n);
      end
    end
  end

  assign w_gidx = WW'(int'(w_gsel) * NPG) + WW'(w_nidx);

  always_comb begin
    w_sum = '0;
    for (int g = 0; g < NG; g++)
      w_sum = w_sum + SW'($signed(bus.i_inhbt[g*IW +: IW]));
    w_inh = w_sum[IW-1:0];
    if (w_sum > L_MAX)
      w_inh = L_MAX[IW-1:0];
    else if (w_sum < L_MIN)
      w_inh = L_MIN[IW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.i_clr)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_min     <= '0;
      r_g       <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_win     <= '0;
      r_max_o   <= '0;
      r_none    <= 1'b0;
      r_inh     <= '0;
      r_inh_upd <= 1'b0;
    end else begin
      if (bus.i_clr) begin
        r_inh     <= '0;
        r_inh_upd <= 1'b0;
      end else begin
        r_inh_upd <= w_inh_all;
        if (w_inh_all)
          r_inh <= w_inh;
      end
      if (!bus.i_clr) begin
        if (r_state == S_IDLE && bus.i_start) begin
          r_cnt <= bus.i_cnt;
          r_min <= bus.i_min_cnt;
          r_g   <= '0;
          r_max <= '0;
          r_idx <= '0;
        end else if (r_state == S_SCAN) begin
          if (!w_last) begin
            // strict compare keeps the lowest global index on ties
            if (w_gmax > r_max) begin
              r_max <= w_gmax;
              r_idx <= w_gidx;
            end
            r_g <= r_g + 1'b1;
          end else begin
            r_max_o <= r_max;
            if (r_max < r_min) begin
              r_none <= 1'b1;
              r_win  <= '0;
            end else begin
              r_none <= 1'b0;
              r_win  <= r_idx;
            end
          end
        end
      end
    end
  end

  assign bus.o_busy    = (r_state != S_IDLE);
  assign bus.o_valid   = (r_state == S_DONE);
  assign bus.o_winner  = r_win;
  assign bus.o_max     = r_max_o;
  assign bus.o_none    = r_none;
  assign bus.o_inh     = r_inh;
  assign bus.o_inh_upd = r_inh_upd;
endmodule

// File: tb/tb_wta_selector.sv
// tb_wta_selector: directed stimulus with result and
// inhibition scoreboards for wta_selector.
module tb_wta_selector;
  localparam int NG  = 8;
  localparam int NPG = 18;
  localparam int CW  = 7;
  localparam int IW  = 25;
  localparam int WW  = $clog2(NG*NPG);

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  int   cyc;
  int   n_valid;
  int   n0;

  typedef struct {
    logic [WW-1:0] w;
    logic [CW-1:0] m;
    logic          n;
    int            c;
  } res_t;

  res_t          q[$];
  logic [IW-1:0] iq[$];
  res_t          r;

  wta_selector_if #(.NG(NG), .NPG(NPG), .CW(CW), .IW(IW)) bus ();

  wta_selector #(
    .NG(NG), .NPG(NPG), .CW(CW), .IW(IW),
    .INH_MAX(655360), .INH_MIN(-655360)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NG*NPG; i++)
      bus.i_cnt[i*CW +: CW] = CW'(v);
  endtask

  task automatic set_one(input int idx, input int v);
    bus.i_cnt[idx*CW +: CW] = CW'(v);
  endtask

  task automatic set_inh(input int v);
    for (int g = 0; g < NG; g++)
      bus.i_inhbt[g*IW +: IW] = IW'(v);
  endtask

  task automatic start(input int mn, input int w,
                       input int m, input logic n);
    res_t e;
    bus.i_min_cnt = CW'(mn);
    bus.i_start   = 1'b1;
    tick();
    bus.i_start = 1'b0;
    e.w = WW'(w);
    e.m = CW'(m);
    e.n = n;
    e.c = cyc + NG + 1;
    q.push_back(e);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && q.size() != 0; k++)
      tick();
    chk("done_in_time", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic inh_step(input logic [NG-1:0] v,
                          input int exp);
    bus.i_inh_valid = v;
    if (&v) iq.push_back(IW'(exp));
    tick();
    bus.i_inh_valid = '0;
    tick();
    chk("inh_seen", 64'(iq.size()), 64'd0);
    iq.delete();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.o_valid) begin
        n_valid++;
        chk("valid_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          r = q.pop_front();
          chk("winner", 64'(bus.o_winner), 64'(r.w));
          chk("max", 64'(bus.o_max), 64'(r.m));
          chk("none", 64'(bus.o_none), 64'(r.n));
          chk("latency", 64'(cyc), 64'(r.c));
        end
      end
      if (bus.o_inh_upd) begin
        chk("upd_expected", 64'(iq.size() != 0), 64'd1);
        if (iq.size() != 0)
          chk("inh", 64'(bus.o_inh), 64'(iq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    n_valid = 0;
    reset_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_clr = 1'b0;
    bus.i_cnt = '0;
    bus.i_min_cnt = '0;
    bus.i_inhbt = '0;
    bus.i_inh_valid = '0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_winner", 64'(bus.o_winner), 64'd0);
    chk("rst_max", 64'(bus.o_max), 64'd0);
    chk("rst_none", 64'(bus.o_none), 64'd0);
    chk("rst_inh", 64'(bus.o_inh), 64'd0);
    chk("rst_upd", 64'(bus.o_inh_upd), 64'd0);
    reset_n = 1'b1;

    set_all(10);
    set_one(59, 40);
    start(1, 59, 40, 1'b0);
    chk("busy_scan", 64'(bus.o_busy), 64'd1);
    wait_done();

    set_all(0);
    set_one(1*NPG+2, 50);
    set_one(6*NPG+0, 50);
    start(1, 20, 50, 1'b0);
    wait_done();

    set_all(0);
    start(0, 0, 0, 1'b0);
    wait_done();

    set_all(3);
    set_one(100, 4);
    start(5, 0, 4, 1'b1);
    wait_done();
    chk("none_hold", 64'(bus.o_none), 64'd1);

    set_all(0);
    set_one(143, 127);
    start(127, 143, 127, 1'b0);
    wait_done();

    set_all(0);
    set_one(2*NPG+7, 30);
    set_one(2*NPG+3, 30);
    start(1, 39, 30, 1'b0);
    wait_done();

    set_inh(100000);
    inh_step('1, 655360);
    set_inh(-100000);
    inh_step('1, -655360);
    set_inh(0);
    bus.i_inhbt[0*IW +: IW] = IW'(1000);
    bus.i_inhbt[3*IW +: IW] = IW'(-66);
    bus.i_inhbt[7*IW +: IW] = IW'(300);
    inh_step('1, 1234);
    set_inh(5);
    inh_step(8'h7F, 0);
    chk("inh_hold", 64'(bus.o_inh), 64'(IW'(1234)));
    chk("upd_low", 64'(bus.o_inh_upd), 64'd0);

    n0 = n_valid;
    set_all(10);
    set_one(59, 40);
    start(1, 59, 40, 1'b0);
    set_all(0);
    set_one(0, 100);
    tick();
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_done();
    repeat (15) tick();
    chk("single_valid", 64'(n_valid - n0), 64'd1);

    set_all(0);
    set_one(7, 99);
    start(1, 7, 99, 1'b0);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    q.delete();
    chk("mid_busy", 64'(bus.o_busy), 64'd0);
    chk("mid_valid", 64'(bus.o_valid), 64'd0);
    chk("mid_winner", 64'(bus.o_winner), 64'd0);
    chk("mid_max", 64'(bus.o_max), 64'd0);
    chk("mid_inh", 64'(bus.o_inh), 64'd0);
    reset_n = 1'b1;
    n0 = n_valid;
    repeat (15) tick();
    chk("rst_no_valid", 64'(n_valid - n0), 64'd0);

    start(1, 7, 99, 1'b0);
    wait_done();

    set_inh(0);
    bus.i_inhbt[2*IW +: IW] = IW'(1234);
    inh_step('1, 1234);
    n0 = n_valid;
    set_all(0);
    set_one(20, 60);
    start(1, 20, 60, 1'b0);
    repeat (3) tick();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    q.delete();
    repeat (15) tick();
    chk("clr_no_valid", 64'(n_valid - n0), 64'd0);
    chk("clr_busy", 64'(bus.o_busy), 64'd0);
    chk("clr_win_held", 64'(bus.o_winner), 64'd7);
    chk("clr_max_held", 64'(bus.o_max), 64'd99);
    chk("clr_inh", 64'(bus.o_inh), 64'd0);

    inh_step('1, 1234);
    bus.i_clr = 1'b1;
    bus.i_start = 1'b1;
    bus.i_inh_valid = '1;
    tick();
    bus.i_clr = 1'b0;
    bus.i_start = 1'b0;
    bus.i_inh_valid = '0;
    chk("cs_busy", 64'(bus.o_busy), 64'd0);
    chk("cs_inh", 64'(bus.o_inh), 64'd0);
    chk("cs_upd", 64'(bus.o_inh_upd), 64'd0);
    chk("cs_valid", 64'(bus.o_valid), 64'd0);
    tick();
    chk("cs_busy2", 64'(bus.o_busy), 64'd0);
    chk("cs_valid2", 64'(bus.o_valid), 64'd0);
    chk("cs_upd2", 64'(bus.o_inh_upd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
